// File: rtl/dram_read_loader.sv
// DRAM read loader: turns a load command into fixed-length read bursts, forwards
// returned beats to the swizzle stage and waits for it to flush before the next command.
module dram_read_loader #(
   parameter int MEM_CTRL_DWIDTH = 40,
   parameter int DRAM_AWIDTH     = 32,
   parameter int RAM_ADDR_WIDTH  = 12,
   parameter int BURST_LEN       = 40,
   parameter int NB_WIDTH        = 10,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [DRAM_AWIDTH-1:0]     cmd_dram_addr,
   input  logic [NB_WIDTH-1:0]        cmd_num_bursts,
   input  logic [RAM_ADDR_WIDTH-1:0]  cmd_ram_start_addr,
   output logic                       rd_req_valid,
   input  logic                       rd_req_ready,
   output logic [DRAM_AWIDTH-1:0]     rd_req_addr,
   input  logic                       rd_data_valid,
   input  logic [MEM_CTRL_DWIDTH-1:0] rd_data,
   output logic                       data_valid,
   output logic [MEM_CTRL_DWIDTH-1:0] mem_ctrl_data_in,
   output logic                       mem_ctrl_data_last,
   output logic [RAM_ADDR_WIDTH-1:0]  ram_start_addr,
   input  logic                       swz_ready,
   output logic                       busy,
   output logic                       done,
   output logic                       err_unexpected
);

   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [OW-1:0]          MAX_OS    = OW'(MAX_OUTSTANDING);
   localparam logic [BW-1:0]          BEAT_LAST = BW'(BURST_LEN - 1);
   localparam logic [DRAM_AWIDTH-1:0] ADDR_STEP = DRAM_AWIDTH'(BURST_LEN);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t state, state_nxt;

   logic [NB_WIDTH-1:0] num_bursts, bursts_to_issue, bursts_returned;
   logic [OW-1:0]       outstanding;
   logic [BW-1:0]       beat_cnt;
   logic                seen_low, zero_done;
   logic                accept, req_fire, beat_ok, burst_done, final_beat;

   assign accept     = cmd_valid & cmd_ready;
   assign req_fire   = rd_req_valid & rd_req_ready;
   // Beats with nothing outstanding are strays (e.g. from bursts cut off by reset).
   assign beat_ok    = rd_data_valid & (outstanding != '0);
   assign burst_done = beat_ok & (beat_cnt == BEAT_LAST);
   assign final_beat = burst_done & (bursts_returned == num_bursts - NB_WIDTH'(1));
   assign busy       = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      cmd_ready    = 1'b0;
      rd_req_valid = 1'b0;
      done         = zero_done;
      case (state)
         IDLE: begin
            cmd_ready = swz_ready;
            if (accept && (cmd_num_bursts != '0)) state_nxt = RUN;
         end
         RUN: begin
            rd_req_valid = (bursts_to_issue != '0) && (outstanding < MAX_OS);
            if (final_beat) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (swz_ready && seen_low) begin
               state_nxt = IDLE;
               done      = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_req_addr        <= '0;
         num_bursts         <= '0;
         bursts_to_issue    <= '0;
         bursts_returned    <= '0;
         outstanding        <= '0;
         beat_cnt           <= '0;
         seen_low           <= 1'b0;
         zero_done          <= 1'b0;
         ram_start_addr     <= '0;
         data_valid         <= 1'b0;
         mem_ctrl_data_in   <= '0;
         mem_ctrl_data_last <= 1'b0;
         err_unexpected     <= 1'b0;
      end else begin
         data_valid         <= beat_ok;
         mem_ctrl_data_in   <= rd_data;
         mem_ctrl_data_last <= final_beat;
         zero_done          <= accept && (cmd_num_bursts == '0);
         if (rd_data_valid && (outstanding == '0)) err_unexpected <= 1'b1;

         if (accept) begin
            rd_req_addr     <= cmd_dram_addr;
            num_bursts      <= cmd_num_bursts;
            bursts_to_issue <= cmd_num_bursts;
            bursts_returned <= '0;
            beat_cnt        <= '0;
            ram_start_addr  <= cmd_ram_start_addr;
            seen_low        <= 1'b0;
         end else begin
            if (req_fire) begin
               rd_req_addr     <= rd_req_addr + ADDR_STEP;
               bursts_to_issue <= bursts_to_issue - NB_WIDTH'(1);
            end
            if (beat_ok)    beat_cnt        <= burst_done ? '0 : beat_cnt + BW'(1);
            if (burst_done) bursts_returned <= bursts_returned + NB_WIDTH'(1);
            // Issue and completion in the same cycle cancel out.
            case ({req_fire, burst_done})
               2'b10:   outstanding <= outstanding + OW'(1);
               2'b01:   outstanding <= outstanding - OW'(1);
               default: outstanding <= outstanding;
            endcase
            if ((state != IDLE) && !swz_ready) seen_low <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dram_read_loader.sv
// Directed bench for dram_read_loader: a default instance (a_*) and a narrow-address,
// two-outstanding instance (b_*) share all inputs; each test watches one of them.
module tb_dram_read_loader;
   localparam int DW = 40;

   logic          clk = 1'b0, reset = 1'b1;
   logic          cmd_valid = 1'b0;
   logic [31:0]   cmd_dram_addr = '0;
   logic [9:0]    cmd_num_bursts = '0;
   logic [11:0]   cmd_ram_start_addr = '0;
   logic          rd_req_ready = 1'b0, rd_data_valid = 1'b0, swz_ready = 1'b1;
   logic [DW-1:0] rd_data = '0;

   logic          a_cmd_ready, a_rd_req_valid, a_data_valid, a_last, a_busy, a_done, a_err;
   logic [31:0]   a_rd_req_addr;
   logic [DW-1:0] a_data;
   logic [11:0]   a_ram;
   logic          b_cmd_ready, b_rd_req_valid, b_data_valid, b_last, b_busy, b_done, b_err;
   logic [7:0]    b_rd_req_addr;
   logic [DW-1:0] b_data;
   logic [11:0]   b_ram;

   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   dram_read_loader u_a (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(a_cmd_ready),
      .cmd_dram_addr(cmd_dram_addr), .cmd_num_bursts(cmd_num_bursts),
      .cmd_ram_start_addr(cmd_ram_start_addr), .rd_req_valid(a_rd_req_valid),
      .rd_req_ready(rd_req_ready), .rd_req_addr(a_rd_req_addr), .rd_data_valid(rd_data_valid),
      .rd_data(rd_data), .data_valid(a_data_valid), .mem_ctrl_data_in(a_data),
      .mem_ctrl_data_last(a_last), .ram_start_addr(a_ram), .swz_ready(swz_ready),
      .busy(a_busy), .done(a_done), .err_unexpected(a_err));

   dram_read_loader #(.DRAM_AWIDTH(8), .MAX_OUTSTANDING(2)) u_b (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(b_cmd_ready),
      .cmd_dram_addr(cmd_dram_addr[7:0]), .cmd_num_bursts(cmd_num_bursts),
      .cmd_ram_start_addr(cmd_ram_start_addr), .rd_req_valid(b_rd_req_valid),
      .rd_req_ready(rd_req_ready), .rd_req_addr(b_rd_req_addr), .rd_data_valid(rd_data_valid),
      .rd_data(rd_data), .data_valid(b_data_valid), .mem_ctrl_data_in(b_data),
      .mem_ctrl_data_last(b_last), .ram_start_addr(b_ram), .swz_ready(swz_ready),
      .busy(b_busy), .done(b_done), .err_unexpected(b_err));

   // Leaves time at posedge+1 with all inputs idle.
   task automatic do_reset();
      reset = 1'b1; cmd_valid = 1'b0; rd_req_ready = 1'b0; rd_data_valid = 1'b0;
      rd_data = '0; swz_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (a_cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %0b exp 1", a_cmd_ready); end
      checks++;
      if ({a_rd_req_valid, a_data_valid, a_last, a_busy, a_done, a_err} !== 6'b0) begin
         errors++; $display("FAIL reset_flags got %b exp 000000",
                            {a_rd_req_valid, a_data_valid, a_last, a_busy, a_done, a_err});
      end
      checks++;
      if (a_rd_req_addr !== 32'h0 || a_data !== '0 || a_ram !== 12'h0) begin
         errors++; $display("FAIL reset_values got addr %h data %h ram %h exp 0", a_rd_req_addr, a_data, a_ram);
      end
      swz_ready = 1'b0; #1;
      checks++;
      if (a_cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_swz_low_ready got %0b exp 0", a_cmd_ready); end
      swz_ready = 1'b1; #1;
   endtask

   task automatic test_single_burst();
      int nreq, nbeat, ndone, done_c;
      nreq = 0; nbeat = 0; ndone = 0; done_c = -1;
      do_reset();
      cmd_dram_addr = 32'h100; cmd_num_bursts = 10'd1; cmd_ram_start_addr = 12'h020; rd_req_ready = 1'b1;
      for (int c = 0; c < 90; c++) begin
         cmd_valid     = (c == 0);
         rd_data_valid = (c >= 3 && c < 43);
         rd_data       = DW'(c - 2);
         swz_ready     = !(c >= 43 && c < 83);
         #1;
         if (a_rd_req_valid && rd_req_ready) begin
            nreq++; checks++;
            if (a_rd_req_addr !== 32'h100) begin errors++; $display("FAIL single_req_addr got %h exp 100", a_rd_req_addr); end
         end
         if (a_done) begin ndone++; done_c = c; end
         @(posedge clk); #1;
         checks++;
         if (a_data_valid !== rd_data_valid || a_busy !== (c < 83)) begin
            errors++; $display("FAIL single_dv_busy c=%0d got dv %0b busy %0b exp dv %0b busy %0b",
                               c, a_data_valid, a_busy, rd_data_valid, (c < 83));
         end
         if (a_data_valid) begin
            nbeat++; checks++;
            if (a_data !== DW'(nbeat) || a_last !== (nbeat == 40)) begin
               errors++; $display("FAIL single_beat got data %0d last %0b exp data %0d last %0b",
                                  a_data, a_last, nbeat, (nbeat == 40));
            end
         end else if (a_last !== 1'b0) begin
            errors++; $display("FAIL single_last_idle got %0b exp 0", a_last);
         end
         checks++;
         if (a_ram !== 12'h020) begin errors++; $display("FAIL single_ram got %h exp 020", a_ram); end
      end
      checks++;
      if (nreq != 1 || nbeat != 40) begin errors++; $display("FAIL single_counts got req %0d beats %0d exp 1 40", nreq, nbeat); end
      checks++;
      if (ndone != 1 || done_c != 83) begin errors++; $display("FAIL single_done got n %0d at %0d exp 1 at 83", ndone, done_c); end
   endtask

   task automatic test_three_bursts();
      int fired, sent, nbeat, ndone, done_c;
      logic [7:0] exp_addr [3];
      exp_addr = '{8'h00, 8'h28, 8'h50};
      fired = 0; sent = 0; nbeat = 0; ndone = 0; done_c = -1;
      do_reset();
      cmd_dram_addr = 32'h0; cmd_num_bursts = 10'd3; cmd_ram_start_addr = 12'h155; rd_req_ready = 1'b1;
      for (int c = 0; c < 145; c++) begin
         cmd_valid     = (c == 0);
         rd_data_valid = (c >= 10) && (sent < fired * 40);
         rd_data       = DW'(sent + 1);
         swz_ready     = !(c >= 132 && c < 137);
         #1;
         if (b_rd_req_valid && rd_req_ready) begin
            checks++;
            if (fired >= 3) begin
               errors++; $display("FAIL three_extra_req got req %0d exp 3 max", fired + 1);
            end else if (b_rd_req_addr !== exp_addr[fired]) begin
               errors++; $display("FAIL three_req_addr got %h exp %h", b_rd_req_addr, exp_addr[fired]);
            end
            if (fired == 2) begin
               checks++;
               if (sent != 40) begin errors++; $display("FAIL three_req3_withheld got beats %0d exp 40", sent); end
            end
            fired++;
         end
         if (b_done) begin ndone++; done_c = c; end
         if (rd_data_valid) sent++;
         @(posedge clk); #1;
         checks++;
         if (b_data_valid !== rd_data_valid) begin
            errors++; $display("FAIL three_dv c=%0d got %0b exp %0b", c, b_data_valid, rd_data_valid);
         end
         if (b_data_valid) begin
            nbeat++; checks++;
            if (b_data !== DW'(nbeat) || b_last !== (nbeat == 120)) begin
               errors++; $display("FAIL three_beat got data %0d last %0b exp data %0d last %0b",
                                  b_data, b_last, nbeat, (nbeat == 120));
            end
         end
      end
      checks++;
      if (fired != 3 || nbeat != 120) begin errors++; $display("FAIL three_counts got req %0d beats %0d exp 3 120", fired, nbeat); end
      checks++;
      if (ndone != 1 || done_c != 137) begin errors++; $display("FAIL three_done got n %0d at %0d exp 1 at 137", ndone, done_c); end
   endtask

   task automatic test_zero_bursts();
      do_reset();
      cmd_dram_addr = 32'h40; cmd_num_bursts = 10'd0; rd_req_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         cmd_valid = (c == 0);
         #1;
         checks++;
         if (a_rd_req_valid !== 1'b0 || a_done !== (c == 1)) begin
            errors++; $display("FAIL zero_req_done c=%0d got req %0b done %0b exp req 0 done %0b",
                               c, a_rd_req_valid, a_done, (c == 1));
         end
         @(posedge clk); #1;
         checks++;
         if (a_busy !== 1'b0) begin errors++; $display("FAIL zero_busy c=%0d got %0b exp 0", c, a_busy); end
      end
   endtask

   task automatic test_backpressure();
      int fired, sent, nbeat, ndone, done_c;
      logic [31:0] exp_addr [2];
      exp_addr = '{32'h200, 32'h228};
      fired = 0; sent = 0; nbeat = 0; ndone = 0; done_c = -1;
      do_reset();
      cmd_dram_addr = 32'h200; cmd_num_bursts = 10'd2; cmd_ram_start_addr = 12'h0AB;
      for (int c = 0; c < 150; c++) begin
         cmd_valid     = (c == 0);
         rd_req_ready  = (c >= 6);
         rd_data_valid = (c >= 10) && ((c % 3) != 0) && (sent < fired * 40);
         rd_data       = DW'(sent + 7);
         swz_ready     = !(c >= 135 && c < 140);
         #1;
         if (c >= 1 && c <= 5) begin
            checks++;
            if (a_rd_req_valid !== 1'b1 || a_rd_req_addr !== 32'h200) begin
               errors++; $display("FAIL bp_hold c=%0d got req %0b addr %h exp 1 200", c, a_rd_req_valid, a_rd_req_addr);
            end
         end
         if (a_rd_req_valid && rd_req_ready) begin
            checks++;
            if (fired >= 2) begin
               errors++; $display("FAIL bp_extra_req got req %0d exp 2 max", fired + 1);
            end else if (a_rd_req_addr !== exp_addr[fired]) begin
               errors++; $display("FAIL bp_req_addr got %h exp %h", a_rd_req_addr, exp_addr[fired]);
            end
            fired++;
         end
         if (a_done) begin ndone++; done_c = c; end
         if (rd_data_valid) sent++;
         @(posedge clk); #1;
         checks++;
         if (a_data_valid !== rd_data_valid) begin
            errors++; $display("FAIL bp_dv c=%0d got %0b exp %0b", c, a_data_valid, rd_data_valid);
         end
         if (a_data_valid) begin
            nbeat++; checks++;
            if (a_data !== DW'(nbeat + 6) || a_last !== (nbeat == 80)) begin
               errors++; $display("FAIL bp_beat got data %0d last %0b exp data %0d last %0b",
                                  a_data, a_last, nbeat + 6, (nbeat == 80));
            end
         end
      end
      checks++;
      if (fired != 2 || nbeat != 80 || a_ram !== 12'h0AB) begin
         errors++; $display("FAIL bp_counts got req %0d beats %0d ram %h exp 2 80 0ab", fired, nbeat, a_ram);
      end
      checks++;
      if (ndone != 1 || done_c != 140) begin errors++; $display("FAIL bp_done got n %0d at %0d exp 1 at 140", ndone, done_c); end
   endtask

   task automatic test_stray_beat();
      int ndv_after;
      ndv_after = 0;
      do_reset();
      cmd_dram_addr = 32'h300; cmd_num_bursts = 10'd1; cmd_ram_start_addr = 12'h011; rd_req_ready = 1'b1;
      for (int c = 0; c < 50; c++) begin
         cmd_valid     = (c == 0);
         reset         = (c == 13 || c == 14);
         rd_data_valid = (c >= 3 && c < 13) || (c >= 15 && c < 45);
         rd_data       = DW'(c);
         #1;
         @(posedge clk); #1;
         if (c == 12) begin
            checks++;
            if (a_err !== 1'b0 || a_busy !== 1'b1) begin
               errors++; $display("FAIL stray_pre got err %0b busy %0b exp 0 1", a_err, a_busy);
            end
         end
         if (c == 14) begin
            checks++;
            if (a_err !== 1'b0) begin errors++; $display("FAIL stray_in_reset_err got %0b exp 0", a_err); end
         end
         if (c >= 13 && a_data_valid) ndv_after++;
      end
      checks++;
      if (ndv_after != 0) begin errors++; $display("FAIL stray_forwarded got %0d beats exp 0", ndv_after); end
      checks++;
      if (a_err !== 1'b1 || a_busy !== 1'b0 || a_cmd_ready !== 1'b1) begin
         errors++; $display("FAIL stray_post got err %0b busy %0b ready %0b exp 1 0 1", a_err, a_busy, a_cmd_ready);
      end
   endtask

   task automatic test_addr_wrap();
      int fired;
      logic [7:0] exp_addr [2];
      exp_addr = '{8'hF0, 8'h18};
      fired = 0;
      do_reset();
      cmd_dram_addr = 32'hF0; cmd_num_bursts = 10'd2; rd_req_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         cmd_valid = (c == 0);
         #1;
         if (b_rd_req_valid && rd_req_ready) begin
            checks++;
            if (fired >= 2) begin
               errors++; $display("FAIL wrap_extra_req got req %0d exp 2 max", fired + 1);
            end else if (b_rd_req_addr !== exp_addr[fired]) begin
               errors++; $display("FAIL wrap_req_addr got %h exp %h", b_rd_req_addr, exp_addr[fired]);
            end
            fired++;
         end
         @(posedge clk); #1;
      end
      checks++;
      if (fired != 2) begin errors++; $display("FAIL wrap_count got %0d exp 2", fired); end
   endtask

   initial begin
      test_reset();
      test_single_burst();
      test_three_bursts();
      test_zero_bursts();
      test_backpressure();
      test_stray_beat();
      test_addr_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
